// File: rtl/mips32_fetch_unit.sv
// mips32_fetch_unit
//   Decoupled instruction-fetch front end. Issues word reads to a
//   synchronous-read instruction memory (1-cycle latency), buffers the
//   returned words with their PCs in a prefetch FIFO, and hands them to
//   decode over a valid/ready handshake. A downstream redirect flushes
//   everything and restarts fetch; a misaligned redirect target halts
//   fetch and raises a sticky fault until an aligned redirect or reset.
//
// Ports
//   clk             clock, rising edge
//   rst             asynchronous active-low reset
//   imem_en         instruction-memory read strobe
//   imem_addr       instruction-memory word address (fpc[IMEM_AW+1:2])
//   imem_data       read data, valid the cycle after imem_en
//   redirect_valid  redirect request (highest priority)
//   redirect_pc     redirect target
//   inst_valid      FIFO head holds an instruction
//   inst_ready      decode accepts the head this cycle
//   inst            head instruction word
//   inst_pc         PC of head instruction
//   inst_pc4        inst_pc + 4 (wrapping)
//   fetch_fault     sticky misaligned-redirect flag
module mips32_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                IMEM_AW  = 8,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [31:0]        inst,
  output logic [ADDR_W-1:0]  inst_pc,
  output logic [ADDR_W-1:0]  inst_pc4,
  output logic               fetch_fault
);

  localparam int              PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CW      = $clog2(DEPTH + 1);
  localparam logic [PW-1:0]   LAST    = PW'(DEPTH - 1);
  localparam logic [CW:0]     DEPTH_C = (CW + 1)'(DEPTH);

  logic [ADDR_W-1:0] fpc;
  logic [ADDR_W-1:0] pend_pc;
  logic              pending;
  logic              fault;
  logic [CW-1:0]     count;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;

  logic [31:0]       buf_inst [DEPTH];
  logic [ADDR_W-1:0] buf_pc   [DEPTH];

  logic [CW:0]       used;
  logic              issue;
  logic              push;
  logic              pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // Credits are counted against buffered entries plus the one in flight,
  // so a returning word always has a free slot. A pop in the same cycle
  // deliberately does not release a credit, keeping the issue path short.
  assign used       = {1'b0, count} + (CW + 1)'(pending);
  assign issue      = rst && !redirect_valid && !fault && (used < DEPTH_C);
  assign push       = pending && !redirect_valid;
  assign pop        = inst_valid && inst_ready && !redirect_valid;

  assign imem_en     = issue;
  assign imem_addr   = fpc[IMEM_AW+1:2];
  assign inst_valid  = (count != '0);
  assign inst        = buf_inst[head];
  assign inst_pc     = buf_pc[head];
  assign inst_pc4    = buf_pc[head] + ADDR_W'(4);
  assign fetch_fault = fault;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpc     <= RESET_PC;
      pend_pc <= '0;
      pending <= 1'b0;
      fault   <= 1'b0;
      count   <= '0;
      head    <= '0;
      tail    <= '0;
    end else if (redirect_valid) begin
      // Dropping pending discards the word returning next cycle.
      fpc     <= redirect_pc;
      fault   <= (redirect_pc[1:0] != 2'b00);
      pending <= 1'b0;
      count   <= '0;
      head    <= '0;
      tail    <= '0;
    end else begin
      if (issue) begin
        pend_pc <= fpc;
        fpc     <= fpc + ADDR_W'(4);
      end
      pending <= issue;
      if (push) tail <= ptr_inc(tail);
      if (pop)  head <= ptr_inc(head);
      if (push && !pop)
        count <= count + CW'(1);
      else if (!push && pop)
        count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_inst[tail] <= imem_data;
      buf_pc[tail]   <= pend_pc;
    end
  end

endmodule
